bcd_to_bin_enc: RTL and testbench



---
 rtl/bcd_to_bin_enc.sv | 72 +++++++
 tb/tb_bcd_to_bin_enc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_enc.sv
// bcd_to_bin_enc: packed multi-digit BCD to plain binary.
// Provides a combinational result (bin/err) and a one-cycle registered
// copy (bin_q/err_q/valid_q) for timing-critical memory address ports.
// Out-of-range digits (A-F) still contribute their raw 4-bit value and raise err.
// OUT_WIDTH may be narrowed below the natural width to drop the high bits.
// OUT_WIDTH must not exceed $clog2(10**DIGITS) + 4.

module bcd_to_bin_enc #(
   parameter int DIGITS      = 6,
   parameter int DIGIT_WIDTH = 4,
   parameter int OUT_WIDTH   = $clog2(10**DIGITS)
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          En,
   input  logic [DIGITS*DIGIT_WIDTH-1:0] bcd,
   output logic [OUT_WIDTH-1:0]          bin,
   output logic                          err,
   output logic [OUT_WIDTH-1:0]          bin_q,
   output logic                          err_q,
   output logic                          valid_q
);

   // Four guard bits above the decimal range hold the worst case of all digits = 15.
   localparam int FULL_W = $clog2(10**DIGITS) + 4;

   logic [FULL_W-1:0] acc_s;
   logic [3:0]        digit_s;
   logic              err_s;

   // A digit is out of range when it encodes 10..15.
   function automatic logic digit_invalid(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

   // Multiply-accumulate chain from the most significant digit: acc = acc*10 + d.
   always_comb begin
      acc_s   = {FULL_W{1'b0}};
      digit_s = 4'd0;
      err_s   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         digit_s = bcd[i*DIGIT_WIDTH +: 4];
         acc_s   = (acc_s << 3) + (acc_s << 1) + {{(FULL_W-4){1'b0}}, digit_s};
         if (digit_invalid(digit_s)) begin
            err_s = 1'b1;
         end else begin
            err_s = err_s;
         end
      end
   end

   assign bin = acc_s[OUT_WIDTH-1:0];
   assign err = err_s;

   // Capture register: load on En, valid pulses one cycle per capture.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         bin_q   <= {OUT_WIDTH{1'b0}};
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (En) begin
         bin_q   <= bin;
         err_q   <= err;
         valid_q <= 1'b1;
      end else begin
         bin_q   <= bin_q;
         err_q   <= err_q;
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_enc.sv
// Directed-vector bench for bcd_to_bin_enc (6-digit default plus a 2-digit
// 7-bit bootloader-address instance).

module tb_bcd_to_bin_enc;

   logic        Clk;
   logic        Rst_n;
   logic        En;
   logic [23:0] bcd;
   logic [19:0] bin;
   logic        err;
   logic [19:0] bin_q;
   logic        err_q;
   logic        valid_q;

   logic        En2;
   logic [7:0]  bcd2;
   logic [6:0]  bin2;
   logic        err2;
   logic [6:0]  bin2_q;
   logic        err2_q;
   logic        valid2_q;

   int checks;
   int failures;

   bcd_to_bin_enc u_dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .En      (En),
      .bcd     (bcd),
      .bin     (bin),
      .err     (err),
      .bin_q   (bin_q),
      .err_q   (err_q),
      .valid_q (valid_q)
   );

   bcd_to_bin_enc #(.DIGITS(2), .OUT_WIDTH(7)) u_dut2 (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .En      (En2),
      .bcd     (bcd2),
      .bin     (bin2),
      .err     (err2),
      .bin_q   (bin2_q),
      .err_q   (err2_q),
      .valid_q (valid2_q)
   );

   // 10 ns clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Registered outputs of the 6-digit instance, checked together.
   task automatic check_q(input string tag, input int exp_bin, input logic exp_err, input logic exp_valid);
      check_val({tag, ".bin_q"},   32'(bin_q),   32'(exp_bin));
      check_val({tag, ".err_q"},   32'(err_q),   32'(exp_err));
      check_val({tag, ".valid_q"}, 32'(valid_q), 32'(exp_valid));
   endtask

   logic [23:0] vec_bcd [3];
   int          vec_bin [3];

   initial begin
      checks   = 0;
      failures = 0;
      Rst_n    = 1'b0;
      En       = 1'b0;
      bcd      = 24'h000000;
      En2      = 1'b0;
      bcd2     = 8'h00;

      // Reset state
      #12;
      check_q("reset", 0, 1'b0, 1'b0);

      // Release and idle with En=0 for 3 cycles
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge Clk);
         #1;
         check_q("idle", 0, 1'b0, 1'b0);
      end

      // Back-to-back captures of valid patterns
      vec_bcd[0] = 24'h000000; vec_bin[0] = 0;
      vec_bcd[1] = 24'h999999; vec_bin[1] = 999999;
      vec_bcd[2] = 24'h123456; vec_bin[2] = 123456;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         bcd = vec_bcd[k];
         En  = 1'b1;
         #1;
         check_val("comb.bin", 32'(bin), 32'(vec_bin[k]));
         check_val("comb.err", 32'(err), 32'd0);
         @(posedge Clk);
         #1;
         check_q("b2b", vec_bin[k], 1'b0, 1'b1);
      end

      // Out-of-range digit still converts, flags err
      @(negedge Clk);
      bcd = 24'h00001A;
      En  = 1'b1;
      #1;
      check_val("bad.bin", 32'(bin), 32'd20);
      check_val("bad.err", 32'(err), 32'd1);
      @(posedge Clk);
      #1;
      check_q("bad", 20, 1'b1, 1'b1);

      // Single En pulse then hold
      @(negedge Clk);
      bcd = 24'h000042;
      En  = 1'b1;
      @(posedge Clk);
      #1;
      check_q("pulse", 42, 1'b0, 1'b1);
      @(negedge Clk);
      bcd = 24'h000007;
      En  = 1'b0;
      #1;
      check_val("hold.bin", 32'(bin), 32'd7);
      @(posedge Clk);
      #1;
      check_q("hold1", 42, 1'b0, 1'b0);
      @(posedge Clk);
      #1;
      check_q("hold2", 42, 1'b0, 1'b0);

      // Asynchronous reset mid-stream
      @(negedge Clk);
      bcd = 24'h000500;
      En  = 1'b1;
      @(posedge Clk);
      #1;
      check_q("pre_rst", 500, 1'b0, 1'b1);
      #1;
      Rst_n = 1'b0;
      #1;
      check_q("async_rst", 0, 1'b0, 1'b0);
      check_val("rst.bin", 32'(bin), 32'd500);
      @(posedge Clk);
      #1;
      check_q("rst_edge", 0, 1'b0, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      check_q("post_rst", 500, 1'b0, 1'b1);
      @(negedge Clk);
      En = 1'b0;

      // Two-digit sweep over all valid codes
      for (int t = 0; t < 10; t++) begin
         for (int o = 0; o < 10; o++) begin
            bcd2 = {4'(t), 4'(o)};
            #1;
            check_val("sweep.bin", 32'(bin2), 32'(t * 10 + o));
            check_val("sweep.err", 32'(err2), 32'd0);
         end
      end

      // Two-digit invalid nibbles; high bits past 7 are dropped
      bcd2 = 8'h0A; #1;
      check_val("d2_0A.bin", 32'(bin2), 32'd10);
      check_val("d2_0A.err", 32'(err2), 32'd1);
      bcd2 = 8'hF0; #1;
      check_val("d2_F0.bin", 32'(bin2), 32'd22);
      check_val("d2_F0.err", 32'(err2), 32'd1);
      bcd2 = 8'hFF; #1;
      check_val("d2_FF.bin", 32'(bin2), 32'd37);
      check_val("d2_FF.err", 32'(err2), 32'd1);
      bcd2 = 8'hB5; #1;
      check_val("d2_B5.err", 32'(err2), 32'd1);

      // Two-digit registered path
      @(negedge Clk);
      bcd2 = 8'h73;
      En2  = 1'b1;
      @(posedge Clk);
      #1;
      check_val("d2.bin_q",   32'(bin2_q),   32'd73);
      check_val("d2.valid_q", 32'(valid2_q), 32'd1);
      check_val("d2.err_q",   32'(err2_q),   32'd0);
      @(negedge Clk);
      En2 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
